// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of single-clock 50%-duty programmable dividers with tick strobes
// Optional build macro: CLKDIV_CASCADE_EN (channel i>0 may step on tick[i-1] instead of every clk1).
module clk_div_bank #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk1,
  input  logic              WB_RST_FPGA,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_chan,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic              wr_cascade,
  output logic [NUM_CH-1:0] clk_div_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pend
);

  // tick of the neighbouring lower channel, used as the cascade step source
  logic [NUM_CH-1:0] prev_tick;
  assign prev_tick = {tick[NUM_CH-2:0], 1'b0};

`ifndef CLKDIV_CASCADE_EN
  logic unused_cascade;
  assign unused_cascade = wr_cascade;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_shadow;
    logic [DIV_W-1:0] div_active;
    logic             out_q;
    logic             tick_q;
    logic             pend_q;
    logic             step;
    logic             running;
    logic             advance;
    logic             at_end;
    logic             rise;
    logic             wr_hit;
    logic             apply;

`ifdef CLKDIV_CASCADE_EN
    logic casc_shadow;
    logic casc_active;
    assign step = ~casc_active | prev_tick[i];
`else
    assign step = 1'b1;
    logic unused_prev;
    assign unused_prev = prev_tick[i];
`endif

    assign running = chan_en[i] | out_q;
    assign advance = running & step;
    assign at_end  = (cnt == div_active);
    assign rise    = advance & at_end & ~out_q;
    assign wr_hit  = wr_en & (wr_chan == CH_W'(i));
    // a new ratio lands at the start of a high phase, or straight away while idle
    assign apply   = rise | (~running & pend_q);

    always_ff @(posedge clk1 or posedge WB_RST_FPGA) begin
      if (WB_RST_FPGA) begin
        cnt         <= '0;
        div_shadow  <= DIV_W'(DIV_INIT);
        div_active  <= DIV_W'(DIV_INIT);
        out_q       <= 1'b0;
        tick_q      <= 1'b0;
        pend_q      <= 1'b0;
`ifdef CLKDIV_CASCADE_EN
        casc_shadow <= 1'b0;
        casc_active <= 1'b0;
`endif
      end else begin
        tick_q <= rise;
        if (!running) begin
          cnt <= '0;
        end else if (advance) begin
          if (at_end) begin
            cnt   <= '0;
            out_q <= ~out_q;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        if (apply) begin
          div_active  <= div_shadow;
          pend_q      <= 1'b0;
`ifdef CLKDIV_CASCADE_EN
          casc_active <= casc_shadow;
`endif
        end
        // a write in the apply cycle wins: the old shadow is applied, the new one waits
        if (wr_hit) begin
          div_shadow  <= wr_div;
          pend_q      <= 1'b1;
`ifdef CLKDIV_CASCADE_EN
          casc_shadow <= wr_cascade & (i != 0);
`endif
        end
      end
    end

    assign clk_div_out[i] = out_q;
    assign tick[i]        = tick_q;
    assign div_pend[i]    = pend_q;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised, fully synchronous bank of NUM_CH programmable clock dividers, all running off clk1.
- Replaces ripple chains of toggle flops clocked by divided clocks; every flop in this block is on clk1.
- Each channel produces a 50%-duty divided clock (routed to a gclkbuff outside this block) and a one-cycle rising-edge tick strobe.
- Divide ratios are written at run time and applied glitch-free on period boundaries.

Parameters:
- NUM_CH, 4, number of divider channels (>=2).
- DIV_W, 16, width of each divide field.
- DIV_INIT, 0, divide value loaded on reset into all channels.

Ports:
- clk1  in  1  fabric clock; all state on its rising edge.
- WB_RST_FPGA  in  1  reset, asynchronous, active-high; clock clk1.
- chan_en  in  NUM_CH  per-channel run enable.
- wr_en  in  1  one-cycle write strobe for the divide register.
- wr_chan  in  $clog2(NUM_CH)  target channel of the write.
- wr_div  in  DIV_W  new divide value.
- wr_cascade  in  1  cascade-mode bit for the target channel (see Optional Feature).
- clk_div_out  out  NUM_CH  divided clock outputs, registered.
- tick  out  NUM_CH  one-cycle pulse coincident with each 0->1 transition of clk_div_out[i].
- div_pend  out  NUM_CH  high while a written divide value is waiting to be applied.

Behaviour:
- Reset: clk_div_out=0, tick=0, div_pend=0. Per channel: cnt=0, div_shadow=DIV_INIT, div_active=DIV_INIT, cascade=0. Asserting reset mid-period clears all of these immediately, including any pending write.
- Advance event: a clk1 cycle in which the channel's counter steps. In non-cascade mode, every cycle in which the channel is running is an advance event.
- Counting, per channel:
  - On an advance event with cnt==div_active: cnt<=0 and clk_div_out toggles.
  - Otherwise: cnt<=cnt+1.
  - Result: half-period = div_active+1 advance events; period = 2*(div_active+1). div=0 gives clk1/2.
- Running condition: chan_en[i] | clk_div_out[i]. A disable therefore always completes the current high phase.
- Idle: when chan_en=0 and clk_div_out=0, cnt holds 0 and the output stays low.
- Start: after chan_en rises, the first 0->1 transition occurs div_active+1 advance events later.
- Tick: tick[i] is registered alongside the output and is high for exactly the cycle in which clk_div_out[i] is first high.
- Write:
  - If wr_en and wr_chan<NUM_CH: div_shadow[wr_chan]<=wr_div, cascade[wr_chan]<=wr_cascade, div_pend<=1.
  - If wr_chan>=NUM_CH: the write is ignored with no side effects.
- Apply:
  - div_active<=div_shadow and div_pend<=0 at the advance event that toggles the output 0->1, so the new ratio starts on a full-period boundary. The high phase of that period already uses the new value.
  - A pending value is applied immediately, on the next cycle, while the channel is idle.
- Simultaneous write and apply on the same channel:
  - The apply uses the old div_shadow.
  - The new value lands in div_shadow and div_pend stays 1.
- Widths: cnt and div fields are DIV_W bits. No overflow is possible because the counter resets at div_active.

Optional Feature:
- Macro: CLKDIV_CASCADE_EN.
- Defined: for channel i>0 with cascade[i]=1, advance events are the cycles where tick[i-1]=1 (and the channel is running), rather than every clk1 cycle.
  - This reproduces the divide-by-2/4/8 chain with a single clock domain.
  - Channel 0 ignores its cascade bit.
  - The cascade bit is updated together with div_shadow and takes effect at the same apply point.
- Not defined: the cascade bits are not implemented, wr_cascade is ignored, and all channels count on clk1.

Test Plan:
1. Reset with DIV_INIT=0, all chan_en=1 -> every clk_div_out toggles each cycle (period 2); tick pulses every 2nd cycle; div_pend=0.
2. ch1 running div=0; write ch1 div=3 -> div_pend[1]=1 until the next 0->1 edge; then period 8 (4 high, 4 low) and div_pend[1]=0.
3. ch0 div=2, drop chan_en[0] one cycle after the 0->1 edge -> output stays high 3 cycles total, then goes low and holds; no further ticks; cnt=0.
4. CLKDIV_CASCADE_EN defined; ch0 div=0, ch1 and ch2 cascade=1 div=0 -> periods 2, 4, 8 clk1 cycles; ch2 tick every 8 cycles, all edges phase-aligned to ch0 ticks.
5. Assert WB_RST_FPGA mid-high-phase with a write pending -> clk_div_out=0 and div_pend=0 immediately; after release, channels run at DIV_INIT.
6. NUM_CH=3, write wr_chan=3 div=5 -> no channel changes, div_pend stays 0; a write on an apply cycle keeps div_pend=1 and applies one period later.
